instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage, directly upstream of instruction decode.
- Maintains the PC and issues single-outstanding word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents one instruction per cycle with its PC+4 and a done qualifier to decode.
- Accepts jump/branch redirects from downstream and discards stale in-flight data.

Parameters:
RESET_PC  32'h0000_0000  PC fetched first after reset
BUF_DEPTH  2  prefetch FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-low
stall_in  input  1  decode cannot accept; hold outputs, no pop
redirect  input  1  take redirect_pc this cycle (driven by decode jFlag/branch resolve)
redirect_pc  input  32  new fetch address; bits [1:0] ignored, forced 2'b00
imem_req  output  1  read request valid
imem_addr  output  32  word-aligned read address, stable while imem_req=1 and no ack
imem_ack  input  1  read data valid this cycle; may coincide with first req cycle
imem_rdata  input  32  instruction word, sampled when imem_req&imem_ack
instr  output  32  instruction to decode
PC_out  output  32  address of instr plus 4 (feeds decode PC_in)
done_out  output  1  instr/PC_out valid this cycle, one-cycle pulse per instruction

Behaviour:
- Reset (rst==0 at posedge): pc_q=RESET_PC, req_addr=0, FSM=IDLE, FIFO empty (count=0, pointers 0), discard=0, imem_req=0, imem_addr=0, instr=0, PC_out=0, done_out=0. Reset wins over all inputs, including mid-transaction; a pending ack after reset is ignored.
- FSM states: IDLE, REQ.
  - IDLE: when count < BUF_DEPTH and redirect==0, latch req_addr<=pc_q, go to REQ.
  - REQ: imem_req=1, imem_addr=req_addr. Address must not change until ack.
  - On ack: if discard==0, push {imem_rdata, req_addr+4}. pc_q<=req_addr+4 unless a redirect occurred meanwhile. Clear discard.
  - After ack: stay in REQ with req_addr<=new pc_q if FIFO space remains after this cycle's push/pop; else go to IDLE.
- Redirect (priority over push and pop):
  - Flush FIFO, pc_q<={redirect_pc[31:2],2'b00}, done_out<=0.
  - If in REQ without ack this cycle, set discard=1 and keep the current req_addr until ack.
  - If ack arrives in the same cycle as the redirect, drop the data.
  - Next request uses the new pc_q.
- Output:
  - If FIFO non-empty, stall_in==0, redirect==0: pop head; instr<=head.word, PC_out<=head.pc4, done_out<=1.
  - Otherwise done_out<=0, and instr/PC_out hold their previous values.
  - Push and pop in the same cycle are permitted; count is unchanged.
  - Full FIFO: no new request issued (IDLE). An in-flight request is only issued when space is reserved, so a push never overflows.
- Latency: word acked at edge N appears with done_out=1 after edge N+1 at the earliest (no bypass). Zero-wait memory with no stalls gives one instruction every cycle after fill.
- Arithmetic: 32-bit unsigned PC increment by 4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Stall: FIFO keeps filling up to BUF_DEPTH while stall_in==1; outputs hold, done_out=0.

Test Plan:
- Reset, RESET_PC=0, zero-wait ack, imem_rdata=addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8,...; done_out continuous from 3rd cycle after rst rises; PC_out 4,8,12 with matching instr.
- Ack delayed 3 cycles per request -> imem_addr stable across wait cycles; one done_out pulse per ack; instr order preserved.
- stall_in=1 for 5 cycles mid-stream -> at most 2 requests complete, then imem_req=0; done_out=0 and instr holds; after release, buffered words emerge in order with no loss or duplication.
- redirect=1, redirect_pc=32'h0000_0103 while request to 0x10 is pending (ack 2 cycles later) -> FIFO flushed; data from 0x10 discarded; next imem_addr=0x100; first done_out has PC_out=0x104.
- redirect coinciding with ack and with a pop -> no done_out that cycle; acked word dropped; fetch resumes at the redirect target.
- RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PC_out for FFFF_FFFC is 0. Assert rst=0 mid-wait -> all outputs reach reset values at the next edge.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, prefetch FIFO,
// redirect handling with stale-data discard, one instruction per cycle to decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] PC_out,
    output logic        done_out
);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [31:0]        word_q [BUF_DEPTH];
    logic [31:0]        word_d [BUF_DEPTH];
    logic [31:0]        pc4_q  [BUF_DEPTH];
    logic [31:0]        pc4_d  [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               discard_q, discard_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic               done_q, done_d;

    logic               ack, push, pop;
    logic [31:0]        next_addr;

    always_comb begin
        ack       = (state_q == REQ) && imem_ack;
        pop       = (count_q != '0) && !stall_in && !redirect;
        push      = ack && !discard_q && !redirect;
        next_addr = req_addr_q + 32'd4;

        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        word_d     = word_q;
        pc4_d      = pc4_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        done_d     = 1'b0;

        if (push) begin
            word_d[wr_ptr_q] = imem_rdata;
            pc4_d[wr_ptr_q]  = next_addr;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            pc_d             = next_addr;
        end

        if (pop) begin
            instr_d  = word_q[rd_ptr_q];
            pc_out_d = pc4_q[rd_ptr_q];
            done_d   = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // A request is only launched when a FIFO slot is guaranteed for its data.
        case (state_q)
            IDLE: begin
                if (!redirect && (count_q < DEPTH_C)) begin
                    req_addr_d = pc_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    discard_d = 1'b0;
                    if (count_d < DEPTH_C) begin
                        req_addr_d = pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                word_q[i] <= '0;
                pc4_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            discard_q  <= 1'b0;
            instr_q    <= '0;
            pc_out_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            word_q     <= word_d;
            pc4_q      <= pc4_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            done_q     <= done_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = req_addr_q;
    assign instr     = instr_q;
    assign PC_out    = pc_out_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch against a transaction-level
// model: expected fetch address stream plus a queue of fetched-but-undelivered words.
module tb_instr_fetch;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, stall_in, redirect, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, done_out;
    logic [31:0] imem_addr, instr, PC_out;

    logic        req2, done2;
    logic [31:0] addr2, instr2, pc_out2;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .PC_out(PC_out), .done_out(done_out)
    );

    // Second instance exercising the address wrap from a high reset PC, zero-wait memory.
    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .stall_in(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(req2), .imem_rdata(addr2 ^ 32'hA5A5_0000), .instr(instr2),
        .PC_out(pc_out2), .done_out(done2)
    );

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc4;
    } ent_t;

    ent_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_fetch;
    logic        stale, pend;
    int unsigned wait_left;
    logic        exp_done;
    logic [31:0] held_instr, held_pc;
    logic        want_fetch_v, want_done_v;
    logic [31:0] want_fetch, want_done;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: called at a negedge; drives inputs, advances the model across the
    // coming posedge, then checks the outputs at the following negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] rp,
                        input logic rn, input int unsigned dly);
        logic        a;
        logic        hold_addr;
        logic [31:0] prev_addr;
        ent_t        e;
        a = 1'b0;
        if (imem_req) begin
            if (!pend) begin
                pend      = 1'b1;
                wait_left = dly;
            end
            if (wait_left == 0) a = 1'b1;
            else wait_left--;
        end
        stall_in    = s;
        redirect    = r;
        redirect_pc = rp;
        rst         = rn;
        imem_ack    = a;
        imem_rdata  = a ? mem_word(imem_addr) : $urandom;
        hold_addr   = rn && imem_req && !a;
        prev_addr   = imem_addr;

        exp_done = 1'b0;
        if (!rn) begin
            q.delete();
            exp_fetch  = 32'h0;
            stale      = 1'b0;
            pend       = 1'b0;
            held_instr = '0;
            held_pc    = '0;
        end else if (r) begin
            q.delete();
            exp_fetch = {rp[31:2], 2'b00};
            stale     = imem_req && !a;
            if (a) pend = 1'b0;
        end else begin
            if (q.size() > 0 && !s) begin
                e          = q.pop_front();
                exp_done   = 1'b1;
                held_instr = e.word;
                held_pc    = e.pc4;
            end
            if (imem_req && a) begin
                if (!stale) begin
                    chk("fetch_addr", imem_addr, exp_fetch);
                    if (want_fetch_v) begin
                        chk("redirect_first_fetch", imem_addr, want_fetch);
                        want_fetch_v = 1'b0;
                    end
                    q.push_back('{word: mem_word(exp_fetch), pc4: exp_fetch + 32'd4});
                    exp_fetch = exp_fetch + 32'd4;
                end
                stale = 1'b0;
                pend  = 1'b0;
            end
        end

        @(negedge clk);
        if (!rn) begin
            chk("reset_req", {31'b0, imem_req}, 32'd0);
            chk("reset_addr", imem_addr, 32'd0);
            chk("reset_done", {31'b0, done_out}, 32'd0);
            chk("reset_instr", instr, 32'd0);
            chk("reset_pc_out", PC_out, 32'd0);
        end else begin
            chk("done_out", {31'b0, done_out}, {31'b0, exp_done});
            chk("instr", instr, held_instr);
            chk("pc_out", PC_out, held_pc);
            if (hold_addr) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            chk("fifo_bound", (q.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
            if (exp_done && want_done_v) begin
                chk("redirect_first_done", PC_out, want_done);
                want_done_v = 1'b0;
            end
        end
    endtask

    initial begin
        int          guard;
        logic [31:0] rp;
        rst = 1'b0; stall_in = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        redirect_pc = '0; imem_rdata = '0;
        exp_fetch = '0; stale = 1'b0; pend = 1'b0; wait_left = 0;
        exp_done = 1'b0; held_instr = '0; held_pc = '0;
        want_fetch_v = 1'b0; want_done_v = 1'b0; want_fetch = '0; want_done = '0;
        @(negedge clk);
        step(1'b0, 1'b0, 32'h0, 1'b0, 0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 0);

        // Zero-wait stream from reset, with hand-computed pins on both instances.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 0);
            if (i == 0) begin
                chk("lit_addr0", imem_addr, 32'h0);
                chk("lit_wrap_addr0", addr2, 32'hFFFF_FFF8);
            end
            if (i == 1) begin
                chk("lit_addr1", imem_addr, 32'h4);
                chk("lit_done1", {31'b0, done_out}, 32'd0);
                chk("lit_wrap_addr1", addr2, 32'hFFFF_FFFC);
            end
            if (i == 2) begin
                chk("lit_done2", {31'b0, done_out}, 32'd1);
                chk("lit_pc2", PC_out, 32'h4);
                chk("lit_instr2", instr, 32'hA5A5_0000);
                chk("lit_wrap_addr2", addr2, 32'h0);
                chk("lit_wrap_pc2", pc_out2, 32'hFFFF_FFFC);
                chk("lit_wrap_instr2", instr2, 32'h5A5A_FFF8);
            end
            if (i == 3) begin
                chk("lit_pc3", PC_out, 32'h8);
                chk("lit_instr3", instr, 32'hA5A5_0004);
                chk("lit_wrap_pc3", pc_out2, 32'h0);
                chk("lit_wrap_done3", {31'b0, done2}, 32'd1);
            end
        end

        // Redirect coinciding with an ack and a pop in the zero-wait stream.
        step(1'b0, 1'b1, 32'h0000_0202, 1'b1, 0);
        chk("redir_pop_done", {31'b0, done_out}, 32'd0);
        want_fetch_v = 1'b1; want_fetch = 32'h200;
        want_done_v  = 1'b1; want_done  = 32'h204;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        chk("redir_pop_fetch_seen", {31'b0, want_fetch_v}, 32'd0);
        chk("redir_pop_done_seen", {31'b0, want_done_v}, 32'd0);

        // Stall for 5 cycles: FIFO fills then requests stop.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 0);
        chk("stall_req_off", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 0);

        // Three wait cycles per request.
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 3);

        // Redirect while the request to 0x10 is still waiting for its ack.
        step(1'b0, 1'b0, 32'h0, 1'b0, 2);
        guard = 0;
        while (!(imem_req && imem_addr == 32'h10 && !pend) && guard < 100) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 2);
            guard++;
        end
        chk("reach_addr_10", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 2);
        want_fetch_v = 1'b1; want_fetch = 32'h100;
        want_done_v  = 1'b1; want_done  = 32'h104;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 2);
        chk("redir_wait_fetch_seen", {31'b0, want_fetch_v}, 32'd0);
        chk("redir_wait_done_seen", {31'b0, want_done_v}, 32'd0);

        // Reset asserted while a request is waiting.
        guard = 0;
        while (!(imem_req && pend && wait_left > 0) && guard < 50) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 3);
            guard++;
        end
        chk("reach_mid_wait", (guard < 50) ? 32'd1 : 32'd0, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 0);

        // Randomised traffic: waits, stalls, redirects (some near wrap), rare resets.
        for (int i = 0; i < 600; i++) begin
            rp = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rp,
                 $urandom_range(0, 149) != 0, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
